// File: rtl/packet_flit_encoder_pkg.sv
// Shared types for the packet flit encoder: flit type codes, id widths,
// head-field struct, FSM state encoding and the head checksum helper.
// Optional feature macro: HEAD_FLIT_CHECKSUM_EN (head checksum = XOR of fields).
package packet_flit_encoder_pkg;

    localparam int NODE_ID_WIDTH  = 8;
    localparam int PKT_ID_WIDTH   = 8;
    localparam int CHECKSUM_WIDTH = 8;
    localparam int TYPE_WIDTH     = 2;

    typedef enum logic [1:0] {
        FLIT_HEAD = 2'b00,
        FLIT_BODY = 2'b01,
        FLIT_TAIL = 2'b10,
        FLIT_NOPE = 2'b11
    } flit_type_t;

    typedef logic [NODE_ID_WIDTH-1:0] node_id_t;
    typedef logic [PKT_ID_WIDTH-1:0]  pkt_id_t;

    // Descriptor fields carried in the head flit, MSB-first order.
    typedef struct packed {
        node_id_t src;
        node_id_t dst;
        pkt_id_t  id;
    } head_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PAYLOAD = 2'b01,
        ST_DRAIN   = 2'b10
    } enc_state_t;

`ifdef HEAD_FLIT_CHECKSUM_EN
    // 8-bit XOR over the head fields and the zero-extended flit count.
    function automatic logic [CHECKSUM_WIDTH-1:0] head_checksum(
        input head_fields_t             fields,
        input logic [CHECKSUM_WIDTH-1:0] num
    );
        return fields.src ^ fields.dst ^ fields.id ^ num;
    endfunction
`endif

endpackage

// File: rtl/packet_flit_encoder_head.sv
// encode_head_flit_comb: combinational packer turning descriptor fields into
// a head flit; exact inverse of the router's head-flit decoder.
// Optional feature macro: HEAD_FLIT_CHECKSUM_EN (otherwise checksum is 8'h00).
module encode_head_flit_comb
    import packet_flit_encoder_pkg::*;
#(
    parameter int FLIT_WIDTH     = 64,
    parameter int FLIT_NUM_WIDTH = 4
) (
    input  head_fields_t              fields,
    input  logic [FLIT_NUM_WIDTH-1:0] flit_num,
    output logic [FLIT_WIDTH-1:0]     flit
);

    localparam int PAD_WIDTH = FLIT_WIDTH - TYPE_WIDTH - NODE_ID_WIDTH
                               - NODE_ID_WIDTH - PKT_ID_WIDTH
                               - FLIT_NUM_WIDTH - CHECKSUM_WIDTH;

    logic [CHECKSUM_WIDTH-1:0] checksum_s;

`ifdef HEAD_FLIT_CHECKSUM_EN
    // Checksum over the fields with the flit count zero-extended to 8 bits.
    always_comb begin
        checksum_s = head_checksum(fields, CHECKSUM_WIDTH'(flit_num));
    end
`else
    // Checksum field reserved as zero when the feature is disabled.
    always_comb begin
        checksum_s = 8'h00;
    end
`endif

    // Pack type, src, dst, id, count and checksum MSB-first; zero the rest.
    always_comb begin
        flit = {FLIT_HEAD, fields.src, fields.dst, fields.id, flit_num,
                checksum_s, {PAD_WIDTH{1'b0}}};
    end

endmodule

// File: rtl/packet_flit_encoder.sv
// packet_flit_encoder: serializes one descriptor plus payload words into a
// HEAD flit, BODY flits and a final TAIL flit on a valid/ready flit port.
// Optional feature macro: HEAD_FLIT_CHECKSUM_EN (head checksum field).
module packet_flit_encoder
    import packet_flit_encoder_pkg::*;
#(
    parameter int FLIT_WIDTH     = 64,
    parameter int FLIT_NUM_WIDTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   pkt_valid,
    output logic                                   pkt_ready,
    input  logic [7:0]                             pkt_src,
    input  logic [7:0]                             pkt_dst,
    input  logic [7:0]                             pkt_id,
    input  logic [FLIT_NUM_WIDTH-1:0]              pkt_len,
    input  logic                                   pay_valid,
    output logic                                   pay_ready,
    input  logic [FLIT_WIDTH-2-FLIT_NUM_WIDTH-1:0] pay_data,
    output logic [FLIT_WIDTH-1:0]                  flit_out,
    output logic                                   flit_valid,
    input  logic                                   flit_ready
);

    localparam int PAYLOAD_WIDTH = FLIT_WIDTH - 2 - FLIT_NUM_WIDTH;
    localparam logic [FLIT_NUM_WIDTH-1:0] IDX_ZERO = {FLIT_NUM_WIDTH{1'b0}};
    localparam logic [FLIT_NUM_WIDTH-1:0] IDX_ONE  =
        {{(FLIT_NUM_WIDTH-1){1'b0}}, 1'b1};

    enc_state_t                state_r;
    logic [FLIT_NUM_WIDTH-1:0] idx_r;
    logic [FLIT_NUM_WIDTH-1:0] len_r;
    logic [FLIT_WIDTH-1:0]     flit_out_r;
    logic                      flit_valid_r;
    logic                      pkt_ready_r;

    head_fields_t              head_fields_s;
    logic [FLIT_WIDTH-1:0]     head_flit_s;
    logic                      out_free_s;
    logic                      len_zero_s;
    logic                      last_s;
    logic                      pay_ready_s;

    // Gather descriptor inputs into the head-field struct.
    always_comb begin
        head_fields_s.src = pkt_src;
        head_fields_s.dst = pkt_dst;
        head_fields_s.id  = pkt_id;
    end

    encode_head_flit_comb #(
        .FLIT_WIDTH     (FLIT_WIDTH),
        .FLIT_NUM_WIDTH (FLIT_NUM_WIDTH)
    ) u_head (
        .fields   (head_fields_s),
        .flit_num (pkt_len),
        .flit     (head_flit_s)
    );

    // Output-register availability and payload handshake; combinational in
    // flit_ready so back-to-back flits have no bubble. A zero-length packet
    // never consumes payload.
    always_comb begin
        out_free_s  = !flit_valid_r || flit_ready;
        len_zero_s  = (len_r == IDX_ZERO);
        last_s      = (idx_r == (len_r - IDX_ONE));
        if (state_r == ST_PAYLOAD) begin
            pay_ready_s = out_free_s && !len_zero_s;
        end else begin
            pay_ready_s = 1'b0;
        end
    end

    // Packet FSM with index counter and registered flit output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= IDX_ZERO;
            len_r        <= IDX_ZERO;
            flit_out_r   <= {FLIT_WIDTH{1'b0}};
            flit_valid_r <= 1'b0;
            pkt_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pkt_valid) begin
                        len_r        <= pkt_len;
                        idx_r        <= IDX_ZERO;
                        flit_out_r   <= head_flit_s;
                        flit_valid_r <= 1'b1;
                        pkt_ready_r  <= 1'b0;
                        state_r      <= ST_PAYLOAD;
                    end else begin
                        flit_valid_r <= 1'b0;
                        pkt_ready_r  <= 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    if (out_free_s) begin
                        if (len_zero_s) begin
                            flit_out_r   <= {FLIT_TAIL, IDX_ZERO,
                                             {PAYLOAD_WIDTH{1'b0}}};
                            flit_valid_r <= 1'b1;
                            state_r      <= ST_DRAIN;
                        end else if (pay_valid) begin
                            flit_valid_r <= 1'b1;
                            if (last_s) begin
                                flit_out_r <= {FLIT_TAIL, idx_r, pay_data};
                                state_r    <= ST_DRAIN;
                            end else begin
                                flit_out_r <= {FLIT_BODY, idx_r, pay_data};
                                idx_r      <= idx_r + IDX_ONE;
                            end
                        end else begin
                            flit_valid_r <= 1'b0;
                        end
                    end else begin
                        flit_valid_r <= flit_valid_r;
                    end
                end
                ST_DRAIN: begin
                    if (flit_valid_r && flit_ready) begin
                        flit_valid_r <= 1'b0;
                        idx_r        <= IDX_ZERO;
                        pkt_ready_r  <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else begin
                        flit_valid_r <= flit_valid_r;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    idx_r        <= IDX_ZERO;
                    flit_valid_r <= 1'b0;
                    pkt_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign flit_out   = flit_out_r;
    assign flit_valid = flit_valid_r;
    assign pkt_ready  = pkt_ready_r;
    assign pay_ready  = pay_ready_s;

endmodule

// File: tb/tb_packet_flit_encoder.sv
// Directed testbench for packet_flit_encoder (default 64-bit flits, 4-bit count).
module tb_packet_flit_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [7:0]  pkt_src;
    logic [7:0]  pkt_dst;
    logic [7:0]  pkt_id;
    logic [3:0]  pkt_len;
    logic        pay_valid;
    logic        pay_ready;
    logic [57:0] pay_data;
    logic [63:0] flit_out;
    logic        flit_valid;
    logic        flit_ready;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

`ifdef HEAD_FLIT_CHECKSUM_EN
    localparam logic [7:0] CS_BASIC = 8'h73;  // 12^34^56^03
    localparam logic [7:0] CS_ZERO  = 8'hDD;  // AA^BB^CC^00
    localparam logic [7:0] CS_P1    = 8'h01;  // 01^02^03^01
    localparam logic [7:0] CS_P2    = 8'h05;  // 04^05^06^02
`else
    localparam logic [7:0] CS_BASIC = 8'h00;
    localparam logic [7:0] CS_ZERO  = 8'h00;
    localparam logic [7:0] CS_P1    = 8'h00;
    localparam logic [7:0] CS_P2    = 8'h00;
`endif

    packet_flit_encoder #(
        .FLIT_WIDTH     (64),
        .FLIT_NUM_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_src    (pkt_src),
        .pkt_dst    (pkt_dst),
        .pkt_id     (pkt_id),
        .pkt_len    (pkt_len),
        .pay_valid  (pay_valid),
        .pay_ready  (pay_ready),
        .pay_data   (pay_data),
        .flit_out   (flit_out),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] head_f(input logic [7:0] s, input logic [7:0] d,
                                           input logic [7:0] i, input logic [3:0] n,
                                           input logic [7:0] c);
        return {2'b00, s, d, i, n, c, 26'h0};
    endfunction

    function automatic logic [63:0] body_f(input logic [1:0] t, input logic [3:0] idx,
                                           input logic [57:0] p);
        return {t, idx, p};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; pkt_valid = 1'b0; pkt_src = 8'h00; pkt_dst = 8'h00;
        pkt_id = 8'h00; pkt_len = 4'd0; pay_valid = 1'b0; pay_data = 58'h0;
        flit_ready = 1'b1;

        // Power-on reset
        tick(); tick();
        check("rst_valid", 64'(flit_valid), 64'h0);
        check("rst_flit",  flit_out, 64'h0);
        check("rst_pay_ready", 64'(pay_ready), 64'h0);
        rst_n = 1'b1; #1;
        check("rst_pkt_ready", 64'(pkt_ready), 64'h1);

        // Reset mid-packet: head + one body of a len=3 packet, then reset
        pkt_src = 8'h12; pkt_dst = 8'h34; pkt_id = 8'h56; pkt_len = 4'd3; pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0; pay_valid = 1'b1; pay_data = 58'h0AA; #1;
        check("mid_head", flit_out, head_f(8'h12, 8'h34, 8'h56, 4'd3, CS_BASIC));
        tick();
        pay_valid = 1'b0; #1;
        check("mid_body0", flit_out, body_f(2'b01, 4'd0, 58'h0AA));
        rst_n = 1'b0; #1;
        check("mid_rst_valid", 64'(flit_valid), 64'h0);
        check("mid_rst_flit", flit_out, 64'h0);
        check("mid_rst_pay_ready", 64'(pay_ready), 64'h0);
        tick();
        rst_n = 1'b1; #1;
        check("mid_pkt_ready", 64'(pkt_ready), 64'h1);
        check("mid_idle_valid", 64'(flit_valid), 64'h0);

        // Basic packet: len=3, payloads 1,2,3
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0; pay_valid = 1'b1; pay_data = 58'h1; #1;
        check("basic_head", flit_out, head_f(8'h12, 8'h34, 8'h56, 4'd3, CS_BASIC));
        check("basic_head_valid", 64'(flit_valid), 64'h1);
        check("basic_dec_src", 64'(flit_out[61:54]), 64'h12);
        check("basic_dec_dst", 64'(flit_out[53:46]), 64'h34);
        check("basic_dec_id",  64'(flit_out[45:38]), 64'h56);
        check("basic_dec_num", 64'(flit_out[37:34]), 64'h3);
        check("basic_dec_cs",  64'(flit_out[33:26]), 64'(CS_BASIC));
        check("basic_pkt_busy", 64'(pkt_ready), 64'h0);
        check("basic_pay_ready", 64'(pay_ready), 64'h1);
        tick();
        pay_data = 58'h2; #1;
        check("basic_body0", flit_out, body_f(2'b01, 4'd0, 58'h1));
        tick();
        pay_data = 58'h3; #1;
        check("basic_body1", flit_out, body_f(2'b01, 4'd1, 58'h2));
        tick();
        pay_valid = 1'b0; #1;
        check("basic_tail", flit_out, body_f(2'b10, 4'd2, 58'h3));
        check("basic_drain_pay_ready", 64'(pay_ready), 64'h0);
        check("basic_drain_pkt_ready", 64'(pkt_ready), 64'h0);
        tick();
        check("basic_idle_valid", 64'(flit_valid), 64'h0);
        check("basic_idle_pkt_ready", 64'(pkt_ready), 64'h1);

        // Backpressure: stall 4 cycles on the second body flit
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0; pay_valid = 1'b1; pay_data = 58'h11; #1;
        check("bp_head", flit_out, head_f(8'h12, 8'h34, 8'h56, 4'd3, CS_BASIC));
        tick();
        pay_data = 58'h12; #1;
        check("bp_body0", flit_out, body_f(2'b01, 4'd0, 58'h11));
        tick();
        flit_ready = 1'b0; pay_data = 58'h13; #1;
        for (int i = 0; i < 4; i++) begin
            check("bp_stall_flit", flit_out, body_f(2'b01, 4'd1, 58'h12));
            check("bp_stall_valid", 64'(flit_valid), 64'h1);
            check("bp_stall_pay_ready", 64'(pay_ready), 64'h0);
            tick();
        end
        flit_ready = 1'b1; #1;
        check("bp_release_flit", flit_out, body_f(2'b01, 4'd1, 58'h12));
        check("bp_release_pay_ready", 64'(pay_ready), 64'h1);
        tick();
        pay_valid = 1'b0; #1;
        check("bp_tail", flit_out, body_f(2'b10, 4'd2, 58'h13));
        tick();
        check("bp_idle_pkt_ready", 64'(pkt_ready), 64'h1);

        // Zero-length packet: HEAD then TAIL idx0, payload never consumed
        pkt_src = 8'hAA; pkt_dst = 8'hBB; pkt_id = 8'hCC; pkt_len = 4'd0; pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0; pay_valid = 1'b1; pay_data = 58'h3FF; #1;
        check("len0_head", flit_out, head_f(8'hAA, 8'hBB, 8'hCC, 4'd0, CS_ZERO));
        check("len0_pay_ready_a", 64'(pay_ready), 64'h0);
        tick();
        check("len0_tail", flit_out, body_f(2'b10, 4'd0, 58'h0));
        check("len0_pay_ready_b", 64'(pay_ready), 64'h0);
        pay_valid = 1'b0;
        tick();
        check("len0_idle_valid", 64'(flit_valid), 64'h0);
        check("len0_pkt_ready", 64'(pkt_ready), 64'h1);

        // Back-to-back: second descriptor held valid during packet 1
        pkt_src = 8'h01; pkt_dst = 8'h02; pkt_id = 8'h03; pkt_len = 4'd1; pkt_valid = 1'b1;
        tick();
        pkt_src = 8'h04; pkt_dst = 8'h05; pkt_id = 8'h06; pkt_len = 4'd2;
        pay_valid = 1'b1; pay_data = 58'h77; #1;
        check("b2b_head1", flit_out, head_f(8'h01, 8'h02, 8'h03, 4'd1, CS_P1));
        check("b2b_busy1", 64'(pkt_ready), 64'h0);
        tick();
        pay_valid = 1'b0; #1;
        check("b2b_tail1", flit_out, body_f(2'b10, 4'd0, 58'h77));
        check("b2b_busy2", 64'(pkt_ready), 64'h0);
        tick();
        check("b2b_ready_after_tail", 64'(pkt_ready), 64'h1);
        check("b2b_gap_valid", 64'(flit_valid), 64'h0);
        tick();
        pkt_valid = 1'b0; pay_valid = 1'b1; pay_data = 58'h21; #1;
        check("b2b_head2", flit_out, head_f(8'h04, 8'h05, 8'h06, 4'd2, CS_P2));
        check("b2b_busy3", 64'(pkt_ready), 64'h0);
        tick();
        pay_valid = 1'b0; #1;
        check("b2b_body0", flit_out, body_f(2'b01, 4'd0, 58'h21));
        tick();
        check("bubble_valid", 64'(flit_valid), 64'h0);
        pay_valid = 1'b1; pay_data = 58'h22; #1;
        check("bubble_pay_ready", 64'(pay_ready), 64'h1);
        tick();
        pay_valid = 1'b0; #1;
        check("b2b_tail2", flit_out, body_f(2'b10, 4'd1, 58'h22));
        tick();
        check("b2b_end_valid", 64'(flit_valid), 64'h0);
        check("b2b_end_pkt_ready", 64'(pkt_ready), 64'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
